core_status_uart: RTL and testbench
===================================

# core_status_uart

Test-harness peripheral that sits directly downstream of the CPU core and consumes its `over`/`succ`/`halt_signal` status outputs. Once the core reports completion, it emits one ASCII verdict line ("PASS\r\n" or "FAIL\r\n") on a UART TX pin, 8N1, LSB first. FPGA and silicon runs can therefore report results without waveform access. It produces exactly one report per reset.

## Interface
- `CLKS_PER_BIT`, default 434: clk cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- `clk` input 1: clock clk.
- `rst` input 1: reset rst, synchronous, active-low.
- `over_i` input 1: core run-over flag; 1 = program finished.
- `succ_i` input 1: core success flag; 1 = pass. Valid when `over_i` = 1.
- `halt_i` input 1: debug halt request; 1 = core halted by the debugger.
- `uart_tx_o` output 1: serial line; idles high.
- `busy_o` output 1: 1 while the report is being serialized.
- `done_o` output 1: sticky 1 after the last stop bit, until reset.

## Operation
- Reset values: `uart_tx_o` = 1, `busy_o` = 0, `done_o` = 0, state IDLE, latched verdict = 0, char index = 0, bit counter = 0, baud counter = 0.
- FSM states:
  - **IDLE**: go to ARMED on the first cycle with `over_i` = 0. The core's `over` is 1 straight out of reset, so arming is mandatory before any trigger.
  - **ARMED**: trigger when `over_i` = 1 && `halt_i` = 0. On trigger, latch `succ_i` in the same cycle and go to START.
    - While `halt_i` = 1, no trigger occurs, even if `over_i` = 1.
    - A trigger can fire later if `over_i` is still 1 when `halt_i` drops.
  - **START**: `uart_tx_o` = 0 for CLKS_PER_BIT cycles.
  - **DATA**: 8 bits of the current char, LSB first, each CLKS_PER_BIT cycles.
  - **STOP**: `uart_tx_o` = 1 for CLKS_PER_BIT cycles. Then go to START if more chars remain, else to DONE.
  - **DONE**: `uart_tx_o` = 1, `done_o` = 1. Terminal state; all inputs are ignored until reset.
- Message: "PASS\r\n" (0x50 0x41 0x53 0x53 0x0D 0x0A) if the latched verdict = 1, else "FAIL\r\n" (0x46 0x41 0x49 0x4C 0x0D 0x0A). 6 chars.
- Changes on `succ_i` or `over_i` after the trigger are ignored. The message does not change mid-frame.
- `busy_o` = 1 exactly in START, DATA and STOP.
- Baud counter: counts 0 .. CLKS_PER_BIT−1, then wraps. A bit ends at the wrap. Width is $clog2(CLKS_PER_BIT).
- Reset asserted mid-frame: all state returns to reset values at that edge, so `uart_tx_o` is 1 from the next cycle. A partial char is never completed. The block must re-arm (see `over_i` = 0) before it reports again.

## Timing
- All outputs are registered.
- Trigger seen at edge T: `uart_tx_o` = 0 and `busy_o` = 1 from T+1.
- Each char takes 10·CLKS_PER_BIT cycles; there is no inter-char gap.
- Last stop bit ends at T + 60·CLKS_PER_BIT. At that edge `busy_o` → 0 and `done_o` → 1, both in the same cycle.
- `over_i` and `succ_i` are assumed synchronous to clk. No synchronizer is needed.

## Configuration
- `CORE_STATUS_CYCLE_CNT_EN` defined:
  - A 32-bit counter increments on every ARMED cycle with `halt_i` = 0, including the trigger cycle, and saturates at 0xFFFFFFFF.
  - The message becomes "PASS " or "FAIL ", then 8 uppercase hex digits (MSB nibble first), then "\r\n". That is 15 chars, so the frame ends at T + 150·CLKS_PER_BIT.
  - The counter is frozen at the trigger.
- `CORE_STATUS_CYCLE_CNT_EN` undefined: there is no counter logic, and the message is 6 chars as above.

## Structure
- Shared package `core_status_pkg` holds:
  - the state encoding (IDLE, ARMED, START, DATA, STOP, DONE);
  - ASCII constants for 'P', 'A', 'S', 'F', 'I', 'L', ' ', CR and LF;
  - the message-length constants (6 and 15);
  - the nibble-to-hex-ASCII function.
- One sub-module, `uart_tx_byte`, serializes one byte with a valid/ready handshake and owns the baud counter.
- The top level owns arming, triggering, the verdict latch, message sequencing and the optional counter.

## Test plan
All scenarios use CLKS_PER_BIT = 4.
- **Reset behaviour:** hold `rst` = 0 for 3 cycles → `uart_tx_o` = 1, `busy_o` = 0, `done_o` = 0. Keep `over_i` = 1 continuously after reset → no start bit ever (not armed).
- **Pass report:** `over_i` = 0 for 10 cycles, then `over_i` = 1 with `succ_i` = 1 at edge T → start bit at T+1. Decoded bytes are 0x50 0x41 0x53 0x53 0x0D 0x0A. `done_o` rises at T+240 and `busy_o` falls in the same cycle.
- **Fail report and verdict latch:** same sequence with `succ_i` = 0, and `succ_i` toggling after T → bytes 0x46 0x41 0x49 0x4C 0x0D 0x0A (verdict latched).
- **Halt blocks trigger:** armed, `halt_i` = 1 when `over_i` rises, held for 20 cycles → no start bit. `halt_i` falls at edge H with `over_i` still 1 → start bit at H+1.
- **Reset mid-frame:** `rst` = 0 during the second char → `uart_tx_o` = 1 at the next cycle. After release, `over_i` held at 1 → no output until `over_i` has gone 0 then back to 1.
- **Cycle-count message (`CORE_STATUS_CYCLE_CNT_EN` defined):** 100 unhalted armed cycles including the trigger → "PASS 00000064\r\n", with `done_o` at T+600.

Source files
------------

// File: rtl/core_status_pkg.sv
//------------------------------------------------------------------------------
// Module      : core_status_pkg
// Description : Shared types and constants for the core status UART reporter:
//               state encoding, ASCII message characters, message lengths and
//               the nibble-to-hex-ASCII helper.
//               Optional feature macro: CORE_STATUS_CYCLE_CNT_EN
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package core_status_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [7:0] ASCII_P  = 8'h50;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_F  = 8'h46;
  localparam logic [7:0] ASCII_I  = 8'h49;
  localparam logic [7:0] ASCII_L  = 8'h4C;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // "PASS\r\n" / "FAIL\r\n" and the counted form "PASS 0000ABCD\r\n"
  localparam int unsigned MSG_LEN_BASE = 6;
  localparam int unsigned MSG_LEN_CNT  = 15;

  // Uppercase hex digit for one nibble
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_byte.sv
//------------------------------------------------------------------------------
// Module      : uart_tx_byte
// Description : 8N1 LSB-first serializer for one byte at a time. A byte is
//               accepted on valid_i && ready_o; ready_o is also raised on the
//               last cycle of a stop bit so back-to-back bytes have no gap.
//               Owns the baud counter (0 .. CLKS_PER_BIT-1, bit ends at wrap).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_byte
  import core_status_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int               BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              bit_end;

  assign bit_end = (baud_q == BAUD_LAST);
  assign ready_o = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end);
  assign tx_o    = tx_q;
  assign busy_o  = busy_q;

  // Next-state for the bit sequencer; line level and busy are precomputed so they leave a flop
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (state_q inside {ST_START, ST_DATA, ST_STOP}) begin
      baud_d = bit_end ? '0 : baud_q + BAUD_ONE;
    end
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          state_d = ST_START;
          shift_d = data_i;
          tx_d    = 1'b0;
          bit_d   = 3'd0;
          baud_d  = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (valid_i) begin
            // Next char starts immediately: no inter-char idle time
            state_d = ST_START;
            shift_d = data_i;
            tx_d    = 1'b0;
            bit_d   = 3'd0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d == ST_START) || (state_d == ST_DATA) || (state_d == ST_STOP);
  end

  // Serializer registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/core_status_uart.sv
//------------------------------------------------------------------------------
// Module      : core_status_uart
// Description : Watches the core's over/succ/halt status and, once armed and
//               triggered, sends one "PASS\r\n" or "FAIL\r\n" line over UART.
//               One report per reset. With CORE_STATUS_CYCLE_CNT_EN defined
//               the line carries the armed-cycle count as 8 hex digits.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module core_status_uart
  import core_status_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic over_i,
  input  logic succ_i,
  input  logic halt_i,
  output logic uart_tx_o,
  output logic busy_o,
  output logic done_o
);

`ifdef CORE_STATUS_CYCLE_CNT_EN
  localparam int unsigned MSG_LEN = MSG_LEN_CNT;
`else
  localparam int unsigned MSG_LEN = MSG_LEN_BASE;
`endif
  localparam logic [3:0] MSG_LEN_W = 4'(MSG_LEN);

  // ST_START here means "message in flight"; the serializer walks START/DATA/STOP per char
  state_e     state_q, state_d;
  logic       verdict_q, verdict_d;
  logic [3:0] char_idx_q, char_idx_d;
  logic       done_q, done_d;

  logic       trigger;
  logic       verdict;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] char_byte;

  assign trigger  = (state_q == ST_ARMED) && over_i && !halt_i;
  // First char goes out on the trigger cycle itself, before the latch has loaded
  assign verdict  = (state_q == ST_ARMED) ? succ_i : verdict_q;
  assign tx_valid = trigger || ((state_q == ST_START) && (char_idx_q != MSG_LEN_W));
  assign done_o   = done_q;

`ifdef CORE_STATUS_CYCLE_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  digit;
  logic [3:0]  nib;

  assign digit = 3'(char_idx_q - 4'd5);
  assign nib   = cnt_q[{~digit, 2'b00} +: 4];

  // Saturating count of unhalted armed cycles; stops changing once ARMED is left
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == ST_ARMED) && !halt_i && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Cycle counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Character for the current message position
  always_comb begin
    char_byte = ASCII_LF;
    case (char_idx_q)
      4'd0:    char_byte = verdict ? ASCII_P : ASCII_F;
      4'd1:    char_byte = ASCII_A;
      4'd2:    char_byte = verdict ? ASCII_S : ASCII_I;
      4'd3:    char_byte = verdict ? ASCII_S : ASCII_L;
      4'd4:    char_byte = ASCII_SP;
      4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12:
               char_byte = hex_ascii(nib);
      4'd13:   char_byte = ASCII_CR;
      default: char_byte = ASCII_LF;
    endcase
  end
`else
  // Character for the current message position
  always_comb begin
    char_byte = ASCII_LF;
    case (char_idx_q)
      4'd0:    char_byte = verdict ? ASCII_P : ASCII_F;
      4'd1:    char_byte = ASCII_A;
      4'd2:    char_byte = verdict ? ASCII_S : ASCII_I;
      4'd3:    char_byte = verdict ? ASCII_S : ASCII_L;
      4'd4:    char_byte = ASCII_CR;
      default: char_byte = ASCII_LF;
    endcase
  end
`endif

  // Arming, trigger, verdict latch and message sequencing
  always_comb begin
    state_d    = state_q;
    verdict_d  = verdict_q;
    char_idx_d = char_idx_q;
    done_d     = done_q;
    case (state_q)
      ST_IDLE: begin
        if (!over_i) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (trigger) begin
          state_d   = ST_START;
          verdict_d = succ_i;
        end
      end
      ST_START: begin
        // All chars handed over and the last stop bit just ended
        if ((char_idx_q == MSG_LEN_W) && tx_ready) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (tx_valid && tx_ready) begin
      char_idx_d = char_idx_q + 4'd1;
    end
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      verdict_q  <= 1'b0;
      char_idx_q <= 4'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      verdict_q  <= verdict_d;
      char_idx_q <= char_idx_d;
      done_q     <= done_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk     (clk),
    .rst     (rst),
    .valid_i (tx_valid),
    .data_i  (char_byte),
    .ready_o (tx_ready),
    .tx_o    (uart_tx_o),
    .busy_o  (busy_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_core_status_uart.sv
//------------------------------------------------------------------------------
// Module      : tb_core_status_uart
// Description : Scoreboard bench for core_status_uart. Expected message bytes
//               are queued when a trigger is issued; a UART decoder pops and
//               compares each received byte. Honors CORE_STATUS_CYCLE_CNT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_core_status_uart;

  localparam int CPB = 4;
`ifdef CORE_STATUS_CYCLE_CNT_EN
  localparam int MSG_LEN = 15;
`else
  localparam int MSG_LEN = 6;
`endif

  logic clk = 1'b0;
  logic rst;
  logic over_i;
  logic succ_i;
  logic halt_i;
  logic uart_tx_o;
  logic busy_o;
  logic done_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  core_status_uart #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .over_i    (over_i),
    .succ_i    (succ_i),
    .halt_i    (halt_i),
    .uart_tx_o (uart_tx_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  // Queue the expected report for a verdict and frozen cycle count
  task automatic push_msg(input bit v, input logic [31:0] cnt);
    exp_q.push_back(v ? 8'h50 : 8'h46);
    exp_q.push_back(8'h41);
    exp_q.push_back(v ? 8'h53 : 8'h49);
    exp_q.push_back(v ? 8'h53 : 8'h4C);
`ifdef CORE_STATUS_CYCLE_CNT_EN
    exp_q.push_back(8'h20);
    for (int k = 7; k >= 0; k--) exp_q.push_back(hexc(cnt[k*4 +: 4]));
`else
    if (cnt == 32'hFFFF_FFFF) exp_q.push_back(8'h00); // unreachable marker guard
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // UART monitor: decodes frames and checks against the scoreboard
  int         dec_cnt = 0;
  bit         dec_active = 1'b0;
  logic [7:0] dec_byte = 8'h00;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      dec_active = 1'b0;
    end else if (!dec_active) begin
      if (uart_tx_o === 1'b0) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
        dec_byte   = 8'h00;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt == CPB/2) begin
        check("start_bit", uart_tx_o, 1'b0);
      end else if (dec_cnt > CPB/2 && dec_cnt < CPB/2 + 9*CPB && ((dec_cnt - CPB/2) % CPB) == 0) begin
        dec_byte[(dec_cnt - CPB/2)/CPB - 1] = uart_tx_o;
      end else if (dec_cnt == CPB/2 + 9*CPB) begin
        check("stop_bit", uart_tx_o, 1'b1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", dec_byte, $time);
        end else begin
          check("rx_byte", dec_byte, exp_q.pop_front());
        end
        dec_active = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
  endtask

  // Count cycles the line goes low over n cycles
  task automatic quiet_cycles(input int n, input string name);
    int lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uart_tx_o !== 1'b1) lows++;
      step();
    end
    check(name, lows, 0);
  endtask

  // Wait for done_o after trigger edge T (already at the negedge after T)
  task automatic wait_done(input bit toggle);
    int n = 0;
    logic prev_busy = 1'b0;
    for (int i = 0; i < MSG_LEN*10*CPB + 50; i++) begin
      @(posedge clk);
      n++;
      if (toggle) begin
        #1;
        succ_i = ~succ_i;
        over_i = ~over_i;
      end
      @(negedge clk);
      if (done_o === 1'b1) break;
      prev_busy = busy_o;
    end
    check("done_rise", done_o, 1'b1);
    check("done_cycle", n, MSG_LEN*10*CPB);
    check("busy_fall", busy_o, 1'b0);
    check("busy_before_done", prev_busy, 1'b1);
    check("tx_idle_done", uart_tx_o, 1'b1);
    check("all_bytes_seen", exp_q.size(), 0);
  endtask

  // Arm with n_low cycles of over_i=0, then trigger with verdict v
  task automatic run_report(input int n_low, input bit v, input logic [31:0] cnt, input bit toggle);
    over_i = 1'b0;
    halt_i = 1'b0;
    succ_i = ~v;
    repeat (n_low) step();
    over_i = 1'b1;
    succ_i = v;
    push_msg(v, cnt);
    @(posedge clk);
    @(negedge clk);
    check("start_at_t1", uart_tx_o, 1'b0);
    check("busy_at_t1", busy_o, 1'b1);
    wait_done(toggle);
  endtask

  initial begin
    rst    = 1'b0;
    over_i = 1'b1;
    succ_i = 1'b0;
    halt_i = 1'b0;

    // Reset state, then no report without arming
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", uart_tx_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    step();
    rst = 1'b1;
    quiet_cycles(30, "no_arm_quiet");
    check("no_arm_busy", busy_o, 1'b0);

    // Pass report: 100 over-low edges -> count 0x64
    run_report(100, 1'b1, 32'h64, 1'b0);
    quiet_cycles(20, "one_report_only");
    check("done_sticky", done_o, 1'b1);

    // Fail report, with succ/over wiggling after the trigger
    do_reset();
    run_report(10, 1'b0, 32'h0A, 1'b1);

    // Halt holds off the trigger
    do_reset();
    over_i = 1'b0;
    halt_i = 1'b0;
    repeat (5) step();
    over_i = 1'b1;
    succ_i = 1'b1;
    halt_i = 1'b1;
    quiet_cycles(20, "halt_blocks");
    check("halt_busy", busy_o, 1'b0);
    halt_i = 1'b0;
    push_msg(1'b1, 32'h05);
    @(posedge clk);
    @(negedge clk);
    check("halt_release_start", uart_tx_o, 1'b0);
    wait_done(1'b0);

    // Reset in the middle of the second char
    do_reset();
    over_i = 1'b0;
    repeat (10) step();
    over_i = 1'b1;
    succ_i = 1'b1;
    push_msg(1'b1, 32'h0A);
    @(posedge clk);
    #1;
    repeat (50) step();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_tx", uart_tx_o, 1'b1);
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_done", done_o, 1'b0);
    check("midrst_pending", exp_q.size(), MSG_LEN - 1);
    exp_q.delete();
    #1;
    rst = 1'b1;
    quiet_cycles(40, "midrst_no_rearm");
    run_report(7, 1'b0, 32'h07, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
